// File: rtl/ex_mem_stage_pkg.sv
// Shared constants and types for the EX/MEM pipeline register: control-bit and flag
// positions, payload field widths and the slot-occupancy state encoding.
package ex_mem_stage_pkg;

    localparam int CTRL_W    = 4;
    localparam int FLAG_W    = 4;

    localparam int CTRL_HALT = 3;
    localparam int CTRL_RW   = 2;
    localparam int CTRL_MR   = 1;
    localparam int CTRL_MW   = 0;

    localparam int FLAG_SF   = 3;
    localparam int FLAG_ZF   = 2;
    localparam int FLAG_OF   = 1;
    localparam int FLAG_CF   = 0;

    // Encoded as {skid_valid, main_valid} so the valid bits fall straight out of the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } slot_state_e;

    function automatic int payload_width(input int data_w, input int reg_w);
        return 2 * data_w + reg_w + CTRL_W + FLAG_W;
    endfunction

endpackage

// File: rtl/ex_mem_stage_pipe_slot.sv
// pipe_slot: load-enabled payload register with asynchronous active-low reset,
// used for both the main and skid slots of ex_mem_stage.
module pipe_slot
    import ex_mem_stage_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer (main + skid slot) and a
// registered ex_ready. Optional operand bypass to execute is enabled by EX_MEM_FWD_EN.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [3:0]        ex_flags,
    input  logic [DATA_W-1:0] ex_st_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [3:0]        ex_ctrl,
    input  logic              flush,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_result,
    output logic [3:0]        mem_flags,
    output logic [DATA_W-1:0] mem_st_data,
    output logic [REG_W-1:0]  mem_rd,
    output logic [3:0]        mem_ctrl,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int PW = payload_width(DATA_W, REG_W);

    slot_state_e     state, state_nxt;
    logic            main_valid, skid_valid;
    logic            accept, drain;
    logic            main_load, skid_load, main_from_skid;
    logic [PW-1:0]   ex_payload, main_d, main_q, skid_q;

    assign main_valid = state[0];
    assign skid_valid = state[1];

    // ex_ready comes only from the state register, so no combinational path from mem_ready.
    assign ex_ready  = !skid_valid;
    assign mem_valid = main_valid;

    assign accept = ex_valid && ex_ready;
    assign drain  = main_valid && mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_FULL;
                        skid_load = 1'b1;
                    end else if (drain) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_nxt      = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign ex_payload = {ex_result, ex_flags, ex_st_data, ex_rd, ex_ctrl};
    assign main_d     = main_from_skid ? skid_q : ex_payload;

    pipe_slot #(.W(PW)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     (ex_payload),
        .q     (skid_q)
    );

    assign {mem_result, mem_flags, mem_st_data, mem_rd, mem_ctrl} = main_q;

`ifdef EX_MEM_FWD_EN
    // Loads are excluded: their value is not known until the memory stage completes.
    assign fwd_valid = main_valid && mem_ctrl[CTRL_RW] && !mem_ctrl[CTRL_MR];
    assign fwd_rd    = mem_rd;
    assign fwd_data  = mem_result;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed steps followed by random traffic,
// compared against a 2-deep FIFO reference model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] ex_result;
    logic [3:0]  ex_flags;
    logic [15:0] ex_st_data;
    logic [2:0]  ex_rd;
    logic [3:0]  ex_ctrl;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [15:0] mem_result;
    logic [3:0]  mem_flags;
    logic [15:0] mem_st_data;
    logic [2:0]  mem_rd;
    logic [3:0]  mem_ctrl;
    logic        fwd_valid;
    logic [2:0]  fwd_rd;
    logic [15:0] fwd_data;

    int total = 0;
    int bad   = 0;

    // Model: the stage behaves as a FIFO of capacity 2; entry layout {result,flags,st,rd,ctrl}.
    logic [42:0] mq[$];

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(16), .REG_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_result   (ex_result),
        .ex_flags    (ex_flags),
        .ex_st_data  (ex_st_data),
        .ex_rd       (ex_rd),
        .ex_ctrl     (ex_ctrl),
        .flush       (flush),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_result  (mem_result),
        .mem_flags   (mem_flags),
        .mem_st_data (mem_st_data),
        .mem_rd      (mem_rd),
        .mem_ctrl    (mem_ctrl),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic [3:0] fl,
                         input logic [15:0] st, input logic [2:0] rd, input logic [3:0] ct,
                         input logic mr, input logic fsh);
        ex_valid   = v;
        ex_result  = res;
        ex_flags   = fl;
        ex_st_data = st;
        ex_rd      = rd;
        ex_ctrl    = ct;
        mem_ready  = mr;
        flush      = fsh;
    endtask

    // Compare every DUT output against the model's view of the FIFO.
    task automatic check(input string tag);
        logic [42:0] f;
        logic        fv;
        f  = (mq.size() > 0) ? mq[0] : 43'd0;
        chk({tag, "_mem_valid"}, mem_valid, mq.size() > 0);
        chk({tag, "_ex_ready"}, ex_ready, mq.size() < 2);
        if (mq.size() > 0)
            chk({tag, "_payload"}, {mem_result, mem_flags, mem_st_data, mem_rd, mem_ctrl}, f);
`ifdef EX_MEM_FWD_EN
        fv = (mq.size() > 0) && f[2] && !f[1];
        chk({tag, "_fwd_valid"}, fwd_valid, fv);
        if (fv) begin
            chk({tag, "_fwd_rd"}, fwd_rd, f[6:4]);
            chk({tag, "_fwd_data"}, fwd_data, f[42:27]);
        end
`else
        fv = 1'b0;
        chk({tag, "_fwd_tied"}, {fwd_valid, fwd_rd, fwd_data}, {fv, 19'd0});
`endif
    endtask

    // One clock: update the model with the inputs seen at the edge, then check.
    task automatic tick(input string tag);
        logic acc, drn;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            acc = ex_valid && (mq.size() < 2);
            drn = (mq.size() > 0) && mem_ready;
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back({ex_result, ex_flags, ex_st_data, ex_rd, ex_ctrl});
        end
        #1;
        check(tag);
    endtask

    task automatic fill_full(input logic [15:0] a, input logic [15:0] b);
        drive(1'b1, a, 4'h0, 16'h0, 3'd1, 4'b0100, 1'b0, 1'b0);
        tick("fill_a");
        drive(1'b1, b, 4'h0, 16'h0, 3'd2, 4'b0100, 1'b0, 1'b0);
        tick("fill_b");
        drive(1'b0, 16'h0, 4'h0, 16'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 16'h0, 3'd0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_ex_ready", ex_ready, 1'b1);
        chk("rst_payload", {mem_result, mem_flags, mem_st_data, mem_rd, mem_ctrl}, 43'd0);
        chk("rst_fwd_valid", fwd_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single transfer with latency one.
        drive(1'b1, 16'h1234, 4'b0000, 16'h0, 3'd3, 4'b0100, 1'b1, 1'b0);
        tick("single_acc");
        chk("single_result", mem_result, 16'h1234);
        chk("single_rd", mem_rd, 3'd3);
        drive(1'b0, 16'h0, 4'h0, 16'h0, 3'd0, 4'h0, 1'b1, 1'b0);
        tick("single_drain");
        chk("single_gone", mem_valid, 1'b0);

        // Stall with two back-to-back accepts, then release.
        fill_full(16'h0001, 16'h0002);
        chk("stall_ready_low", ex_ready, 1'b0);
        chk("stall_hold", mem_result, 16'h0001);
        tick("stall_hold2");
        chk("stall_still", mem_result, 16'h0001);
        mem_ready = 1'b1;
        tick("stall_drain1");
        chk("stall_second", mem_result, 16'h0002);
        chk("stall_ready_back", ex_ready, 1'b1);
        tick("stall_drain2");

        // Streaming at full rate never uses the skid slot.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(i), 4'(i), 16'(i + 100), 3'(i), 4'b0100, 1'b1, 1'b0);
            tick("stream");
            chk("stream_result", mem_result, 16'(i));
            chk("stream_ready", ex_ready, 1'b1);
        end
        drive(1'b0, 16'h0, 4'h0, 16'h0, 3'd0, 4'h0, 1'b1, 1'b0);
        tick("stream_end");

        // Flush from FULL discards both held entries and the concurrent accept.
        fill_full(16'h00AA, 16'h00BB);
        drive(1'b1, 16'h00CC, 4'h0, 16'h0, 3'd4, 4'b0100, 1'b1, 1'b1);
        tick("flush");
        chk("flush_empty", mem_valid, 1'b0);
        chk("flush_ready", ex_ready, 1'b1);
        drive(1'b0, 16'h0, 4'h0, 16'h0, 3'd0, 4'h0, 1'b1, 1'b0);
        repeat (3) tick("post_flush");

        // Asynchronous reset while FULL, between clock edges.
        fill_full(16'h0011, 16'h0022);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_valid", mem_valid, 1'b0);
        chk("arst_ex_ready", ex_ready, 1'b1);
        chk("arst_payload", mem_result, 16'h0000);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick("post_arst");

        // Bypass: ALU write-back forwards, a load does not.
        drive(1'b1, 16'hBEEF, 4'h0, 16'h0, 3'd5, 4'b0100, 1'b0, 1'b0);
        tick("fwd_alu");
`ifdef EX_MEM_FWD_EN
        chk("fwd_alu_valid", fwd_valid, 1'b1);
        chk("fwd_alu_rd", fwd_rd, 3'd5);
        chk("fwd_alu_data", fwd_data, 16'hBEEF);
`else
        chk("fwd_off_valid", fwd_valid, 1'b0);
`endif
        drive(1'b1, 16'hBEEF, 4'h0, 16'h0, 3'd5, 4'b0110, 1'b1, 1'b0);
        tick("fwd_load_in");
        drive(1'b0, 16'h0, 4'h0, 16'h0, 3'd0, 4'h0, 1'b1, 1'b0);
        tick("fwd_load");
        chk("fwd_load_valid", fwd_valid, 1'b0);
        tick("fwd_end");

        // Random traffic including halts, flags and occasional flushes.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom), 16'($urandom),
                  3'($urandom), 4'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 29) == 0);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage register between the execute ALU and the data-memory stage of the 16-bit processor.
- Captures the ALU result, flags, store data and write-back control, and presents them to the memory stage with a valid/ready handshake.
- A 2-entry skid buffer (main slot plus skid slot) lets memory stalls be absorbed without a combinational ready path back into execute.

Parameters:
- DATA_W, 16, width of ALU result and store data
- REG_W, 3, width of destination register index

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  execute presents a valid instruction
- ex_ready  out  1  stage can accept; registered, equals !skid_valid
- ex_result  in  DATA_W  ALU Out
- ex_flags  in  4  {SF,ZF,OF,CF} from ALU
- ex_st_data  in  DATA_W  store data (source B value)
- ex_rd  in  REG_W  destination register
- ex_ctrl  in  4  {halt,reg_write,mem_read,mem_write}
- flush  in  1  synchronous kill of all held entries
- mem_valid  out  1  main slot holds a valid instruction
- mem_ready  in  1  memory stage consumes the main slot this cycle
- mem_result, mem_flags, mem_st_data, mem_rd, mem_ctrl  out  as inputs  main-slot contents
- fwd_valid, fwd_rd, fwd_data  out  1/REG_W/DATA_W  bypass to execute (optional feature)

Behaviour:
- Reset (rst_n low, async): main_valid=0, skid_valid=0, so mem_valid=0 and ex_ready=1. All payload outputs 0. fwd_valid=0.
- Accept: a transfer occurs when ex_valid && ex_ready. Drain: a transfer occurs when mem_valid && mem_ready.
- Latency: one cycle from accept to mem_valid when the main slot is empty or draining.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (00): accept -> ONE.
  - ONE (01):
    - accept and drain -> ONE; main loads the new entry.
    - accept without drain -> FULL; new entry goes to skid.
    - drain only -> EMPTY.
  - FULL (11): ex_ready=0, so no accept. Drain -> ONE; skid moves to main.
- The skid slot is only ever written in ONE when an accept arrives without a drain. It never holds data while main is empty.
- Payload outputs are held stable while mem_valid && !mem_ready.
- Flush has priority over accept and drain: next state is EMPTY. An accept in the flush cycle is discarded.
- Bubbles: the payload registers of an invalid slot are not cleared. The consumer qualifies everything with mem_valid.
- No arithmetic is performed; flags pass through bit-exact.
- Halt (ctrl[3]) is ordinary payload; the stage does not stall on it.
- Reset asserted mid-transfer: immediate return to EMPTY regardless of handshake state.

Optional Feature:
- Macro: EX_MEM_FWD_EN.
- Defined:
  - fwd_valid = main_valid && reg_write && !mem_read.
  - fwd_rd = mem_rd.
  - fwd_data = mem_result.
  - All are combinational from main-slot registers and feed execute-stage operand bypass.
- Undefined: fwd_valid, fwd_rd and fwd_data are tied to 0, and no bypass logic is generated.

Decomposition:
- Shared constants go in the existing opcodes include: control-bit positions (CTRL_HALT=3, CTRL_RW=2, CTRL_MR=1, CTRL_MW=0) and flag positions (SF=3, ZF=2, OF=1, CF=0).
- One sub-module, pipe_slot: a load-enabled payload register with async active-low reset, parameterised by width. It is instantiated twice (main, skid). The FSM and muxing stay in ex_mem_stage.

Test Plan:
- Reset, then one accept with ex_result=16'h1234, ex_flags=4'b0000, ex_rd=3, ctrl=4'b0100, mem_ready=1 -> next cycle mem_valid=1, mem_result=16'h1234, mem_rd=3; the following cycle mem_valid=0.
- mem_ready=0, two back-to-back accepts (16'h0001 then 16'h0002) -> after the second accept ex_ready=0 and mem_result stays 16'h0001. Raise mem_ready -> 16'h0001 drains, then 16'h0002 appears, and ex_ready returns to 1.
- Streaming: continuous ex_valid with mem_ready=1 for 8 cycles, data 0..7 -> mem_result sequence 0..7 in order, ex_ready constantly 1, skid never used.
- Flush while in FULL with ex_valid=1 -> next cycle mem_valid=0 and ex_ready=1; no stale entry appears afterwards.
- Assert rst_n=0 asynchronously mid-cycle while FULL -> mem_valid and ex_ready change immediately to 0 and 1 without waiting for a clock edge.
- EX_MEM_FWD_EN defined, main slot holds rd=5, result 16'hBEEF, reg_write=1, mem_read=0 -> fwd_valid=1, fwd_rd=5, fwd_data=16'hBEEF. With mem_read=1 -> fwd_valid=0.
